// File: rtl/pwm_multi.sv
// pwm_multi: W-channel PWM sharing one prescaler and one period counter, with
// double-buffered duty/mode, edge or center alignment and per-channel polarity.

module pwm_multi_checker #(
    parameter int R = 10,
    parameter int W = 4
) (
    input logic         clk,
    input logic         reset,
    input logic         en,
    input logic [W-1:0] polarity,
    input logic [R-1:0] c,
    input logic [W-1:0] pwm_out,
    input logic         period_tick
);
    assert property (@(posedge clk) reset |=> ((pwm_out == {W{1'b0}}) && !period_tick))
        else $error("pwm_multi: outputs not cleared by reset");

    assert property (@(posedge clk) (!reset && !en) |=> (pwm_out == $past(polarity)))
        else $error("pwm_multi: disabled output not at inactive level");

    assert property (@(posedge clk) period_tick |-> (c == {R{1'b0}}))
        else $error("pwm_multi: period_tick without counter at zero");

    assert property (@(posedge clk) period_tick |=> !period_tick)
        else $error("pwm_multi: period_tick longer than one clock");
endmodule

module pwm_multi #(
    parameter int R  = 10,
    parameter int W  = 4,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [DW-1:0]        dvsr,
    input  logic                 mode,
    input  logic [W*(R+1)-1:0]   duty,
    input  logic                 duty_wr,
    input  logic [W-1:0]         polarity,
    output logic [W-1:0]         pwm_out,
    output logic                 period_tick
);
    localparam int DUTY_W = W * (R + 1);

    localparam logic [0:0]        DIR_UP    = 1'b0;
    localparam logic [0:0]        DIR_DOWN  = 1'b1;
    localparam logic [R-1:0]      C_ZERO    = {R{1'b0}};
    localparam logic [R-1:0]      C_ONE     = R'(1'b1);
    localparam logic [R-1:0]      C_MAX     = {R{1'b1}};
    localparam logic [DW-1:0]     Q_ZERO    = {DW{1'b0}};
    localparam logic [DW-1:0]     Q_ONE     = DW'(1'b1);
    localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};

    logic [DW-1:0]     q_r;
    logic [DW-1:0]     q_nxt_s;
    logic              tick_s;
    logic [R-1:0]      c_r;
    logic [R-1:0]      c_nxt_s;
    logic [0:0]        dir_r;
    logic [0:0]        dir_nxt_s;
    logic              boundary_s;
    logic [DUTY_W-1:0] duty_sh_r;
    logic [DUTY_W-1:0] duty_act_r;
    logic              mode_sh_r;
    logic              mode_act_r;
    logic [W-1:0]      raw_s;
    logic [W-1:0]      pwm_out_r;
    logic              period_tick_r;

    // Prescaler: dvsr is compared live so shrinking it below q wraps at once
    always_comb begin
        tick_s  = 1'b0;
        q_nxt_s = Q_ZERO;
        if (en && (q_r >= dvsr)) begin
            tick_s  = 1'b1;
            q_nxt_s = Q_ZERO;
        end else if (en) begin
            q_nxt_s = q_r + Q_ONE;
        end else begin
            q_nxt_s = Q_ZERO;
        end
    end

    // Next counter value and direction for the active alignment mode
    always_comb begin
        c_nxt_s   = c_r;
        dir_nxt_s = dir_r;
        case (dir_r)
            DIR_UP: begin
                if (mode_act_r && (c_r == C_MAX)) begin
                    c_nxt_s   = C_MAX - C_ONE;
                    dir_nxt_s = DIR_DOWN;
                end else begin
                    c_nxt_s   = c_r + C_ONE;
                    dir_nxt_s = DIR_UP;
                end
            end
            DIR_DOWN: begin
                c_nxt_s   = c_r - C_ONE;
                dir_nxt_s = DIR_DOWN;
            end
            default: begin
                c_nxt_s   = C_ZERO;
                dir_nxt_s = DIR_UP;
            end
        endcase
    end

    // A period starts on whichever tick reloads the counter with zero
    assign boundary_s = tick_s && (c_nxt_s == C_ZERO);

    // Prescaler, period counter and direction flag state
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r   <= Q_ZERO;
            c_r   <= C_ZERO;
            dir_r <= DIR_UP;
        end else if (!en) begin
            q_r   <= Q_ZERO;
            c_r   <= C_ZERO;
            dir_r <= DIR_UP;
        end else begin
            q_r <= q_nxt_s;
            if (tick_s) begin
                c_r   <= c_nxt_s;
                dir_r <= boundary_s ? DIR_UP : dir_nxt_s;
            end
        end
    end

    // Shadow capture; never bypasses into the active copy
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_sh_r <= DUTY_ZERO;
            mode_sh_r <= 1'b0;
        end else if (duty_wr) begin
            duty_sh_r <= duty;
            mode_sh_r <= mode;
        end
    end

    // Active copy follows shadow while idle and at every period boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_act_r <= DUTY_ZERO;
            mode_act_r <= 1'b0;
        end else if (!en || boundary_s) begin
            duty_act_r <= duty_sh_r;
            mode_act_r <= mode_sh_r;
        end
    end

    // Per-channel compare, zero-extended so duty = 2^R means always active
    always_comb begin
        raw_s = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            raw_s[i] = ({1'b0, c_r} < duty_act_r[i*(R+1) +: (R+1)]);
        end
    end

    // Registered outputs with live polarity
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out_r     <= {W{1'b0}};
            period_tick_r <= 1'b0;
        end else if (!en) begin
            pwm_out_r     <= polarity;
            period_tick_r <= 1'b0;
        end else begin
            pwm_out_r     <= raw_s ^ polarity;
            period_tick_r <= boundary_s;
        end
    end

    assign pwm_out     = pwm_out_r;
    assign period_tick = period_tick_r;

    pwm_multi_checker #(
        .R(R),
        .W(W)
    ) u_checker (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .polarity    (polarity),
        .c           (c_r),
        .pwm_out     (pwm_out_r),
        .period_tick (period_tick_r)
    );
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi at R=4, W=4: duty levels, center mode, shadow
// timing, polarity/enable, divisor shrink and mid-period reset.
module tb_pwm_multi;
    localparam int R    = 4;
    localparam int W    = 4;
    localparam int DW   = 32;
    localparam int DWID = W * (R + 1);

    localparam logic [DWID-1:0] SCEN1 = {5'd8, 5'd16, 5'd5, 5'd0};

    logic            clk;
    logic            reset;
    logic            en;
    logic [DW-1:0]   dvsr;
    logic            mode;
    logic [DWID-1:0] duty;
    logic            duty_wr;
    logic [W-1:0]    polarity;
    logic [W-1:0]    pwm_out;
    logic            period_tick;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] mask [W];
    int          tick_idx;
    int          tick_cnt;

    pwm_multi #(.R(R), .W(W), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .dvsr        (dvsr),
        .mode        (mode),
        .duty        (duty),
        .duty_wr     (duty_wr),
        .polarity    (polarity),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Disable, load shadow, let the active copy follow, then enable
    task automatic configure(input logic [DW-1:0] dv, input logic md,
                             input logic [DWID-1:0] dt, input logic [W-1:0] pol);
        @(negedge clk);
        en = 1'b0; dvsr = dv; mode = md; duty = dt; polarity = pol; duty_wr = 1'b1;
        @(negedge clk);
        duty_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        en = 1'b1;
    endtask

    task automatic wait_tick(input int budget, output int waited);
        waited = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (period_tick) begin
                waited = k;
                break;
            end
        end
    endtask

    // Record one window of outputs; optionally strobe a duty write after sample wr_at
    task automatic measure(input int len, input int wr_at, input logic [DWID-1:0] wr_val);
        tick_idx = -1;
        tick_cnt = 0;
        for (int i = 0; i < W; i++) mask[i] = 64'h0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            duty_wr = 1'b0;
            for (int i = 0; i < W; i++) mask[i][k] = pwm_out[i];
            if (period_tick) begin
                tick_cnt++;
                tick_idx = k;
            end
            if (k == wr_at) begin
                duty    = wr_val;
                duty_wr = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; dvsr = 32'd0; mode = 1'b0;
        duty = '0; duty_wr = 1'b0; polarity = 4'b0000;
        repeat (3) @(negedge clk);
        vectors++; if (pwm_out !== 4'b0000) begin miscompares++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
        vectors++; if (period_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", period_tick); end
        vectors++; if (dut.q_r !== 32'd0) begin miscompares++; $display("FAIL reset_q: got %0d expected 0", dut.q_r); end
        vectors++; if (dut.c_r !== 4'd0) begin miscompares++; $display("FAIL reset_c: got %0d expected 0", dut.c_r); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_edge_duty();
        int waited;
        logic [63:0] exp_m [W];
        exp_m = '{64'h0, 64'h3FF, 64'hFFFFFFFF, 64'hFFFF};
        configure(32'd1, 1'b0, SCEN1, 4'b0000);
        wait_tick(40, waited);
        vectors++; if (waited !== 32) begin miscompares++; $display("FAIL edge_first_tick: got %0d expected 32", waited); end
        measure(32, -1, SCEN1);
        vectors++; if (tick_idx !== 31 || tick_cnt !== 1) begin miscompares++; $display("FAIL edge_period: got idx %0d cnt %0d expected idx 31 cnt 1", tick_idx, tick_cnt); end
        for (int i = 0; i < W; i++) begin
            vectors++; if (mask[i] !== exp_m[i]) begin miscompares++; $display("FAIL edge_ch%0d: got %h expected %h", i, mask[i], exp_m[i]); end
        end
    endtask

    task automatic test_center();
        int waited;
        logic [63:0] exp_m [W];
        exp_m = '{64'h0, 64'h1, 64'h3FFFFFFF, 64'h3F8000FF};
        configure(32'd0, 1'b1, {5'd8, 5'd16, 5'd1, 5'd0}, 4'b0000);
        wait_tick(40, waited);
        vectors++; if (waited !== 30) begin miscompares++; $display("FAIL center_first_tick: got %0d expected 30", waited); end
        measure(30, -1, '0);
        vectors++; if (tick_idx !== 29 || tick_cnt !== 1) begin miscompares++; $display("FAIL center_period: got idx %0d cnt %0d expected idx 29 cnt 1", tick_idx, tick_cnt); end
        for (int i = 0; i < W; i++) begin
            vectors++; if (mask[i] !== exp_m[i]) begin miscompares++; $display("FAIL center_ch%0d: got %h expected %h", i, mask[i], exp_m[i]); end
        end
    endtask

    task automatic test_shadow();
        int waited;
        configure(32'd1, 1'b0, SCEN1, 4'b0000);
        wait_tick(40, waited);
        vectors++; if (waited !== 32) begin miscompares++; $display("FAIL shadow_first_tick: got %0d expected 32", waited); end
        measure(32, 10, {5'd8, 5'd16, 5'd12, 5'd0});
        vectors++; if (mask[1] !== 64'h3FF) begin miscompares++; $display("FAIL shadow_old_duty: got %h expected 3ff", mask[1]); end
        vectors++; if (tick_idx !== 31) begin miscompares++; $display("FAIL shadow_period_a: got %0d expected 31", tick_idx); end
        measure(32, 30, {5'd8, 5'd16, 5'd3, 5'd0});
        vectors++; if (mask[1] !== 64'hFFFFFF) begin miscompares++; $display("FAIL shadow_new_duty: got %h expected ffffff", mask[1]); end
        measure(32, -1, '0);
        vectors++; if (mask[1] !== 64'hFFFFFF) begin miscompares++; $display("FAIL shadow_boundary_write_held: got %h expected ffffff", mask[1]); end
        measure(32, -1, '0);
        vectors++; if (mask[1] !== 64'h3F) begin miscompares++; $display("FAIL shadow_boundary_write_applied: got %h expected 3f", mask[1]); end
        vectors++; if (tick_idx !== 31) begin miscompares++; $display("FAIL shadow_period_d: got %0d expected 31", tick_idx); end
    endtask

    task automatic test_polarity_enable();
        int waited;
        logic [63:0] exp_m [W];
        exp_m = '{64'h0, 64'hFFFFFC00, 64'hFFFFFFFF, 64'hFFFF0000};
        configure(32'd1, 1'b0, SCEN1, 4'b1010);
        wait_tick(40, waited);
        vectors++; if (waited !== 32) begin miscompares++; $display("FAIL pol_first_tick: got %0d expected 32", waited); end
        measure(32, -1, SCEN1);
        for (int i = 0; i < W; i++) begin
            vectors++; if (mask[i] !== exp_m[i]) begin miscompares++; $display("FAIL pol_ch%0d: got %h expected %h", i, mask[i], exp_m[i]); end
        end
        repeat (5) @(negedge clk);
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            vectors++; if (pwm_out !== 4'b1010) begin miscompares++; $display("FAIL dis_pwm: got %b expected 1010", pwm_out); end
            vectors++; if (period_tick !== 1'b0) begin miscompares++; $display("FAIL dis_tick: got %b expected 0", period_tick); end
            vectors++; if (dut.q_r !== 32'd0) begin miscompares++; $display("FAIL dis_q: got %0d expected 0", dut.q_r); end
            vectors++; if (dut.c_r !== 4'd0) begin miscompares++; $display("FAIL dis_c: got %0d expected 0", dut.c_r); end
        end
        en = 1'b1;
        wait_tick(40, waited);
        vectors++; if (waited !== 32) begin miscompares++; $display("FAIL reenable_tick: got %0d expected 32", waited); end
    endtask

    task automatic test_dvsr_shrink();
        int exp_q [9];
        int exp_c [9];
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        exp_c = '{1, 1, 1, 1, 2, 2, 2, 2, 3};
        configure(32'd20, 1'b0, SCEN1, 4'b0000);
        repeat (15) @(negedge clk);
        vectors++; if (dut.q_r !== 32'd15 || dut.c_r !== 4'd0) begin miscompares++; $display("FAIL shrink_start: got q %0d c %0d expected q 15 c 0", dut.q_r, dut.c_r); end
        dvsr = 32'd3;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            vectors++; if (dut.q_r !== 32'(exp_q[j])) begin miscompares++; $display("FAIL shrink_q%0d: got %0d expected %0d", j, dut.q_r, exp_q[j]); end
            vectors++; if (dut.c_r !== 4'(exp_c[j])) begin miscompares++; $display("FAIL shrink_c%0d: got %0d expected %0d", j, dut.c_r, exp_c[j]); end
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        int cnt;
        int bad;
        configure(32'd1, 1'b0, SCEN1, 4'b0110);
        wait_tick(40, waited);
        vectors++; if (waited !== 32) begin miscompares++; $display("FAIL rst_first_tick: got %0d expected 32", waited); end
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (pwm_out !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_pwm: got %b expected 0000", pwm_out); end
        vectors++; if (period_tick !== 1'b0) begin miscompares++; $display("FAIL rst_mid_tick: got %b expected 0", period_tick); end
        reset = 1'b0;
        cnt = -1;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (pwm_out !== 4'b0110) bad++;
            if (period_tick) begin
                cnt = k;
                break;
            end
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rst_inactive: got %0d bad cycles expected 0", bad); end
        vectors++; if (cnt !== 32) begin miscompares++; $display("FAIL rst_period: got %0d expected 32", cnt); end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (pwm_out !== 4'b0110) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rst_after_boundary: got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_edge_duty();
        test_center();
        test_shadow();
        test_polarity_enable();
        test_dvsr_shrink();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
